// File: rtl/inst_prefetch.sv
// Instruction prefetch unit: issues sram-like fetches from a running PC and buffers
// returned words in a small queue toward decode, with redirect flush and stale-response discard.
module inst_prefetch #(
  parameter logic [31:0] START_ADDR = 32'hBFC00000,
  parameter int          DEPTH      = 4,
  parameter int          MAX_OUT    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  input  logic        jbr_taken,
  input  logic [31:0] jbr_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_addr_exc,
  input  logic        out_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int IW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int SW = ((AW + 1 > OW) ? AW + 1 : OW) + 1;

  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
  localparam logic [OW-1:0] MAXO_C  = OW'(MAX_OUT);
  localparam logic [OW-1:0] O_ONE   = OW'(1);
  localparam logic [AW:0]   C_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] P_ONE   = AW'(1);

  // Issued-PC ring has MAX_OUT entries, which need not be a power of two.
  function automatic logic [IW-1:0] ipc_inc(input logic [IW-1:0] p);
    if (p == IW'(MAX_OUT - 1)) return '0;
    return p + IW'(1);
  endfunction

  logic [31:0]   pc_q, pc_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0] outst_q, outst_d, disc_q, disc_d;
  logic          halt_q, halt_d;
  logic [IW-1:0] iwr_q, iwr_d, ird_q, ird_d;

  logic [31:0] q_pc   [DEPTH];
  logic [31:0] q_inst [DEPTH];
  logic        q_exc  [DEPTH];
  logic [31:0] ipc    [MAX_OUT];

  logic          redirect;
  logic [31:0]   target;
  logic [OW-1:0] live;
  logic          accept, resp, resp_push, mis_push, push, pop;
  logic [31:0]   push_pc, push_inst;
  logic          push_exc;

  always_comb begin
    redirect  = exc_valid | jbr_taken;
    target    = exc_valid ? exc_pc : jbr_target;
    live      = outst_q - disc_q;
    inst_req  = resetn && !redirect && !halt_q && (pc_q[1:0] == 2'b00) &&
                (live < MAXO_C) && (outst_q < MAXO_C) &&
                ((SW'(count_q) + SW'(live)) < DEPTH_S);
    accept    = inst_req & inst_addr_ok;
    resp      = inst_data_ok & (outst_q != '0);
    resp_push = resp & (disc_q == '0) & !redirect;
    // Misaligned fetch turns into a poisoned queue entry instead of a bus request.
    mis_push  = resetn & !redirect & !halt_q & (pc_q[1:0] != 2'b00) &
                (count_q < DEPTH_C) & !resp_push;
    push      = resp_push | mis_push;
    pop       = out_valid & out_ready & !redirect;
    push_pc   = resp_push ? ipc[ird_q] : pc_q;
    push_inst = resp_push ? inst_rdata : 32'h0;
    push_exc  = !resp_push;

    pc_d    = pc_q;
    count_d = count_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    outst_d = outst_q;
    disc_d  = disc_q;
    halt_d  = halt_q;
    iwr_d   = iwr_q;
    ird_d   = ird_q;

    if (accept) begin
      pc_d    = pc_q + 32'd4;
      outst_d = outst_d + O_ONE;
      iwr_d   = ipc_inc(iwr_q);
    end
    if (resp) begin
      outst_d = outst_d - O_ONE;
      ird_d   = ipc_inc(ird_q);
      if (disc_q != '0) disc_d = disc_q - O_ONE;
    end
    if (push) begin
      wr_d    = wr_q + P_ONE;
      count_d = count_d + C_ONE;
    end
    if (pop) begin
      rd_d    = rd_q + P_ONE;
      count_d = count_d - C_ONE;
    end
    if (mis_push) halt_d = 1'b1;
    // Everything still in flight after this cycle's updates belongs to the old path.
    if (redirect) begin
      pc_d    = target;
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
      halt_d  = 1'b0;
      disc_d  = outst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q    <= START_ADDR;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      outst_q <= '0;
      disc_q  <= '0;
      halt_q  <= 1'b0;
      iwr_q   <= '0;
      ird_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      outst_q <= outst_d;
      disc_q  <= disc_d;
      halt_q  <= halt_d;
      iwr_q   <= iwr_d;
      ird_q   <= ird_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_q]   <= push_pc;
      q_inst[wr_q] <= push_inst;
      q_exc[wr_q]  <= push_exc;
    end
    if (accept) ipc[iwr_q] <= pc_q;
  end

  assign inst_addr    = pc_q;
  assign out_valid    = resetn & (count_q != '0);
  assign out_pc       = q_pc[rd_q];
  assign out_inst     = q_inst[rd_q];
  assign out_addr_exc = q_exc[rd_q];
endmodule
